// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Holds one decoded instruction and presents the forwarded operands to the ALU.
module id_ex_stage #(
  parameter int WORDSIZE = 64,
  parameter int REGADDR  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                stall,
  input  logic                flush,
  input  logic [REGADDR-1:0]  rs1_addr,
  input  logic [REGADDR-1:0]  rs2_addr,
  input  logic [REGADDR-1:0]  rd_addr,
  input  logic [WORDSIZE-1:0] rs1_data,
  input  logic [WORDSIZE-1:0] rs2_data,
  input  logic [WORDSIZE-1:0] immediate,
  input  logic [WORDSIZE-1:0] pc,
  input  logic [2:0]          alu_op,
  input  logic                src_a_sel,
  input  logic                src_b_sel,
  input  logic                reg_write,
  input  logic                exmem_reg_write,
  input  logic [REGADDR-1:0]  exmem_rd,
  input  logic [WORDSIZE-1:0] exmem_result,
  input  logic                memwb_reg_write,
  input  logic [REGADDR-1:0]  memwb_rd,
  input  logic [WORDSIZE-1:0] memwb_result,
  output logic [WORDSIZE-1:0] alu_input_a,
  output logic [WORDSIZE-1:0] alu_input_b,
  output logic [2:0]          alu_operation,
  output logic                ex_valid,
  output logic [REGADDR-1:0]  ex_rd,
  output logic                ex_reg_write,
  output logic [WORDSIZE-1:0] ex_store_data
);

  logic                valid_q, valid_d;
  logic [REGADDR-1:0]  rs1_addr_q, rs1_addr_d;
  logic [REGADDR-1:0]  rs2_addr_q, rs2_addr_d;
  logic [REGADDR-1:0]  rd_q, rd_d;
  logic [WORDSIZE-1:0] rs1_data_q, rs1_data_d;
  logic [WORDSIZE-1:0] rs2_data_q, rs2_data_d;
  logic [WORDSIZE-1:0] imm_q, imm_d;
  logic [WORDSIZE-1:0] pc_q, pc_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic                src_a_sel_q, src_a_sel_d;
  logic                src_b_sel_q, src_b_sel_d;
  logic                reg_write_q, reg_write_d;

  logic                exmem_hit1, exmem_hit2, memwb_hit1, memwb_hit2;
  logic [WORDSIZE-1:0] fwd1, fwd2;

  // Forwarding: EX/MEM beats MEM/WB, and x0 is never a forwarding target.
  assign exmem_hit1 = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_addr_q);
  assign exmem_hit2 = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_addr_q);
  assign memwb_hit1 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_addr_q);
  assign memwb_hit2 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_addr_q);

  assign fwd1 = exmem_hit1 ? exmem_result : (memwb_hit1 ? memwb_result : rs1_data_q);
  assign fwd2 = exmem_hit2 ? exmem_result : (memwb_hit2 ? memwb_result : rs2_data_q);

  always_comb begin
    valid_d     = valid_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    alu_op_d    = alu_op_q;
    src_a_sel_d = src_a_sel_q;
    src_b_sel_d = src_b_sel_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      valid_d     = 1'b0;
      rs1_addr_d  = '0;
      rs2_addr_d  = '0;
      rd_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      pc_d        = '0;
      alu_op_d    = '0;
      src_a_sel_d = 1'b0;
      src_b_sel_d = 1'b0;
      reg_write_d = 1'b0;
    end else if (stall) begin
      // Recapture forwarded operands so a producer retiring mid-stall is kept.
      rs1_data_d = fwd1;
      rs2_data_d = fwd2;
    end else begin
      valid_d     = in_valid;
      rs1_addr_d  = rs1_addr;
      rs2_addr_d  = rs2_addr;
      rd_d        = rd_addr;
      rs1_data_d  = rs1_data;
      rs2_data_d  = rs2_data;
      imm_d       = immediate;
      pc_d        = pc;
      alu_op_d    = alu_op;
      src_a_sel_d = src_a_sel;
      src_b_sel_d = src_b_sel;
      reg_write_d = reg_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      alu_op_q    <= '0;
      src_a_sel_q <= 1'b0;
      src_b_sel_q <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      alu_op_q    <= alu_op_d;
      src_a_sel_q <= src_a_sel_d;
      src_b_sel_q <= src_b_sel_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign alu_input_a   = src_a_sel_q ? pc_q : fwd1;
  assign alu_input_b   = src_b_sel_q ? imm_q : fwd2;
  assign ex_store_data = fwd2;
  assign alu_operation = alu_op_q;
  assign ex_valid      = valid_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q & valid_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-forwarding stage of the 64-bit RISC-V core, sitting directly upstream of the ALU. It captures decoded operands and control each cycle, supports stall and flush (bubble insertion), and resolves EX/MEM and MEM/WB data hazards. It then drives the ALU's `input_a`, `input_b` and `operation` ports, plus the destination and store-data fields carried to EX/MEM.

## Interface
- `WORDSIZE`, 64, datapath width
- `REGADDR`, 5, register index width

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  ID holds a valid instruction
- `stall`  in  1  hold stage contents
- `flush`  in  1  replace next contents with a bubble
- `rs1_addr`, `rs2_addr`, `rd_addr`  in  REGADDR  source and destination indices
- `rs1_data`, `rs2_data`  in  WORDSIZE  register-file read values
- `immediate`  in  WORDSIZE  sign-extended immediate
- `pc`  in  WORDSIZE  instruction address
- `alu_op`  in  3  ALU operation code (000 = add)
- `src_a_sel`  in  1  0: rs1, 1: pc
- `src_b_sel`  in  1  0: rs2, 1: immediate
- `reg_write`  in  1  instruction writes rd
- `exmem_reg_write`  in  1  EX/MEM writes its rd
- `exmem_rd`  in  REGADDR  EX/MEM destination
- `exmem_result`  in  WORDSIZE  EX/MEM ALU result
- `memwb_reg_write`  in  1  MEM/WB writes its rd
- `memwb_rd`  in  REGADDR  MEM/WB destination
- `memwb_result`  in  WORDSIZE  MEM/WB writeback value
- `alu_input_a`  out  WORDSIZE  to ALU `input_a`
- `alu_input_b`  out  WORDSIZE  to ALU `input_b`
- `alu_operation`  out  3  to ALU `operation`
- `ex_valid`  out  1  stage holds a real instruction
- `ex_rd`  out  REGADDR  registered rd
- `ex_reg_write`  out  1  registered reg_write, gated by ex_valid
- `ex_store_data`  out  WORDSIZE  forwarded rs2 value, for stores

## Operation
- Registered fields: valid, rs1/rs2/rd addresses, rs1/rs2 data, immediate, pc, alu_op, src selects, reg_write.
- Per rising edge, in priority order:
  - `flush`=1: all fields cleared to zero (bubble). This takes precedence over `stall`.
  - `stall`=1: all fields hold, except rs1/rs2 data, which reload with their current forwarded values. A producer that retires during the stall is therefore not lost.
  - Otherwise: load all fields from the inputs; valid <= `in_valid`.
- Forwarding is combinational from the registered fields, evaluated independently for fwd1 (rs1) and fwd2 (rs2):
  - If `exmem_reg_write` and `exmem_rd`!=0 and `exmem_rd`==rsN addr: use `exmem_result`.
  - Else if `memwb_reg_write` and `memwb_rd`!=0 and `memwb_rd`==rsN addr: use `memwb_result`.
  - Else: use the registered rsN data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Output mapping:
  - `alu_input_a` = `src_a_sel` ? pc : fwd1
  - `alu_input_b` = `src_b_sel` ? immediate : fwd2
  - `ex_store_data` = fwd2
  - `alu_operation` = registered alu_op
- `ex_reg_write` = reg_write & valid. A bubble never writes.
- No arithmetic is performed here. All values pass through at full WORDSIZE without truncation.

## Timing
- Latency: 1 cycle from ID inputs to registered outputs. Forwarding muxes add no cycles.
- Forwarding inputs act within the same cycle. Outputs follow `exmem_*`/`memwb_*` combinationally.
- Reset (asynchronous, immediate, independent of `clk`): every registered field is 0. As a result:
  - `ex_valid`=0, `ex_reg_write`=0, `ex_rd`=0, `alu_operation`=000.
  - `alu_input_a`/`alu_input_b`/`ex_store_data` = 0, unless forwarding matches a nonzero rs address. That cannot occur after reset, since the addresses are 0.
- Reset deasserted mid-stall: the stage stays a bubble until the first non-stalled edge.
- `stall` held for N cycles: outputs other than forwarded operands are unchanged for N cycles.
- `stall` and `flush` asserted together: the bubble wins.
- Bubble contents: rs addresses are 0, so operands are 0 and no forwarding occurs.

## Test plan
- Reset: assert `reset` asynchronously with the stage loaded. All outputs go to 0 immediately, without waiting for a clock edge; `alu_operation`=000.
- Plain load: rs1_data=1, rs2_data=2, alu_op=000, selects=0, in_valid=1, rs1=3, rs2=4. One edge later: `alu_input_a`=0x1, `alu_input_b`=0x2, `ex_valid`=1.
- Forwarding priority, with the stage holding rs1=5:
  - exmem_rd=5 (result 0xAA) and memwb_rd=5 (result 0xBB), both writing: `alu_input_a`=0xAA.
  - Drop `exmem_reg_write`: `alu_input_a`=0xBB.
  - Set rs1=0 with exmem_rd=0: no forwarding.
- Immediate/PC select: src_a_sel=1 with pc=0x1000, src_b_sel=1 with immediate=0xFFFF_FFFF_FFFF_FFF8. `alu_input_a`=0x1000, `alu_input_b`=0xFFFF_FFFF_FFFF_FFF8. `ex_store_data` still equals fwd2.
- Stall capture, with the stage holding rs2=7 (data 0x1):
  - Stall 2 cycles; during cycle 1, memwb writes rd 7 = 0x55. After memwb deasserts, `alu_input_b` stays 0x55.
  - Fields other than rs data unchanged throughout.
- Flush: assert `flush` and `stall` together with reg_write=1 loaded. Next edge: `ex_valid`=0, `ex_reg_write`=0, `ex_rd`=0, operands 0.
